fetch_decode_queue: RTL and testbench

- Elastic instruction buffer between instruction fetch and InstructionDecode.
- Holds fetched (address, instruction) pairs in a circular FIFO.
- Presents the oldest entry to the decode stage with a valid/ready handshake.
- Decouples fetch stalls from back-end stalls; discards all contents on a pipeline flush (branch mispredict or exception redirect).

---
 rtl/fetch_decode_queue_pkg.sv | 10 +
 rtl/fetch_decode_queue.sv | 72 +++++++
 tb/tb_fetch_decode_queue.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_decode_queue_pkg.sv
// fetch_decode_queue_pkg: shared widths and the fetch packet type stored by the queue
package fetch_decode_queue_pkg;
   localparam int FDQ_ADDR_WIDTH = 32;
   localparam int FDQ_DATA_WIDTH = 32;
   localparam int FDQ_DEPTH      = 8;
   typedef struct packed {
      logic [FDQ_ADDR_WIDTH-1:0] instruction_addr;
      logic [FDQ_DATA_WIDTH-1:0] instruction;
   } fetch_packet_t;
endpackage

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: elastic FIFO of (pc, instruction) pairs between fetch and decode
// Ports: clk/rst (async, active high), flush (sync clear);
//        if_valid/if_ready/if_instruction_addr/if_instruction from fetch;
//        id_valid/id_ready/id_instruction_addr/id_instruction to decode (zero when empty);
//        count = current occupancy.
module fetch_decode_queue
   import fetch_decode_queue_pkg::*;
#(
   parameter int ADDR_WIDTH = FDQ_ADDR_WIDTH,
   parameter int DATA_WIDTH = FDQ_DATA_WIDTH,
   parameter int DEPTH      = FDQ_DEPTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         if_valid,
   output logic                         if_ready,
   input  logic [ADDR_WIDTH-1:0]        if_instruction_addr,
   input  logic [DATA_WIDTH-1:0]        if_instruction,
   output logic                         id_valid,
   input  logic                         id_ready,
   output logic [ADDR_WIDTH-1:0]        id_instruction_addr,
   output logic [DATA_WIDTH-1:0]        id_instruction,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   fetch_packet_t   r_mem [DEPTH];
   logic [PW-1:0]   r_head;
   logic [PW-1:0]   r_tail;
   logic [CW-1:0]   r_count;
   logic            w_push;
   logic            w_pop;
   fetch_packet_t   w_head;

   // Ready comes from registered occupancy only, so a pop never opens a slot in the same cycle.
   assign if_ready            = r_count != FULL;
   assign id_valid            = r_count != '0;
   assign w_push              = if_valid & if_ready;
   assign w_pop               = id_valid & id_ready;
   assign w_head              = id_valid ? r_mem[r_head] : '0;
   assign id_instruction_addr = w_head.instruction_addr;
   assign id_instruction      = w_head.instruction;
   assign count               = r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + 1'b1;
         if (w_pop) r_head <= r_head + 1'b1;
         if (w_push != w_pop) r_count <= w_push ? r_count + 1'b1 : r_count - 1'b1;
      end
   end

   // Storage is not reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (w_push && !flush) r_mem[r_tail] <= '{instruction_addr: if_instruction_addr, instruction: if_instruction};
   end

   a_count_bound: assert property (@(posedge clk) disable iff (rst) r_count <= FULL);
   a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) w_pop |-> r_count != '0);
   a_no_push_full: assert property (@(posedge clk) disable iff (rst) w_push |-> r_count != FULL);
endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb_fetch_decode_queue: directed scenario bench for fetch_decode_queue
module tb_fetch_decode_queue;
   logic        clk = 0;
   logic        rst = 0;
   logic        flush = 0;
   logic        if_valid = 0;
   logic        if_ready;
   logic [31:0] if_instruction_addr = 0;
   logic [31:0] if_instruction = 0;
   logic        id_valid;
   logic        id_ready = 0;
   logic [31:0] id_instruction_addr;
   logic [31:0] id_instruction;
   logic [3:0]  count;
   int checks = 0;
   int failures = 0;

   fetch_decode_queue dut (
      .clk(clk), .rst(rst), .flush(flush),
      .if_valid(if_valid), .if_ready(if_ready),
      .if_instruction_addr(if_instruction_addr), .if_instruction(if_instruction),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_instruction_addr(id_instruction_addr), .id_instruction(id_instruction),
      .count(count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1 rst = 1;
      #1;
      checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid got=%b exp=0", id_valid); end
      checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL reset_if_ready got=%b exp=1", if_ready); end
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (id_instruction_addr !== 32'h0) begin failures++; $display("FAIL reset_id_addr got=%h exp=0", id_instruction_addr); end
      checks++; if (id_instruction !== 32'h0) begin failures++; $display("FAIL reset_id_instr got=%h exp=0", id_instruction); end
      step();
      step();
      rst = 0;
      step();
      checks++; if (count !== 4'd0 || id_valid !== 1'b0) begin failures++; $display("FAIL post_reset_empty got count=%0d valid=%b exp 0/0", count, id_valid); end
   endtask

   task automatic test_single_push();
      if_valid = 1; if_instruction_addr = 32'h0; if_instruction = 32'h13; id_ready = 0;
      #1;
      checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL no_bypass got=%b exp=0", id_valid); end
      step();
      if_valid = 0;
      checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", id_valid); end
      checks++; if (id_instruction !== 32'h13) begin failures++; $display("FAIL single_instr got=%h exp=00000013", id_instruction); end
      checks++; if (id_instruction_addr !== 32'h0) begin failures++; $display("FAIL single_addr got=%h exp=0", id_instruction_addr); end
      checks++; if (count !== 4'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", count); end
      id_ready = 1;
      step();
      id_ready = 0;
      checks++; if (count !== 4'd0 || id_valid !== 1'b0) begin failures++; $display("FAIL single_drain got count=%0d valid=%b exp 0/0", count, id_valid); end
   endtask

   task automatic test_fill_drain();
      id_ready = 0;
      for (int i = 0; i < 8; i++) begin
         if_valid = 1; if_instruction_addr = 32'(i * 4); if_instruction = 32'h1000 + 32'(i);
         step();
      end
      checks++; if (count !== 4'd8) begin failures++; $display("FAIL fill_count got=%0d exp=8", count); end
      checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL fill_if_ready got=%b exp=0", if_ready); end
      if_instruction_addr = 32'h20; if_instruction = 32'h9999;
      step();
      if_valid = 0;
      checks++; if (count !== 4'd8) begin failures++; $display("FAIL ninth_push got count=%0d exp=8", count); end
      id_ready = 1;
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (id_instruction_addr !== 32'(i * 4) || id_instruction !== 32'h1000 + 32'(i)) begin
            failures++; $display("FAIL drain_%0d got addr=%h instr=%h exp addr=%h instr=%h", i, id_instruction_addr, id_instruction, i * 4, 32'h1000 + i);
         end
         step();
      end
      id_ready = 0;
      checks++; if (count !== 4'd0 || id_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got count=%0d valid=%b exp 0/0", count, id_valid); end
   endtask

   task automatic test_full_push_pop();
      id_ready = 0;
      for (int i = 0; i < 8; i++) begin
         if_valid = 1; if_instruction_addr = 32'h100 + 32'(i * 4); if_instruction = 32'h2000 + 32'(i);
         step();
      end
      if_instruction_addr = 32'hAA0; if_instruction = 32'hBAD; id_ready = 1;
      #1;
      checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL full_pp_ready got=%b exp=0", if_ready); end
      checks++; if (id_instruction_addr !== 32'h100) begin failures++; $display("FAIL full_pp_head got=%h exp=00000100", id_instruction_addr); end
      step();
      if_valid = 0; id_ready = 0;
      checks++; if (count !== 4'd7) begin failures++; $display("FAIL full_pp_count got=%0d exp=7", count); end
      checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL full_pp_ready_next got=%b exp=1", if_ready); end
      id_ready = 1;
      for (int i = 1; i < 8; i++) begin
         checks++; if (id_instruction_addr !== 32'h100 + 32'(i * 4)) begin failures++; $display("FAIL full_pp_drain_%0d got=%h exp=%h", i, id_instruction_addr, 32'h100 + i * 4); end
         step();
      end
      id_ready = 0;
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL full_pp_empty got=%0d exp=0", count); end
   endtask

   task automatic test_back_to_back();
      id_ready = 1;
      for (int k = 0; k < 20; k++) begin
         if_valid = 1; if_instruction_addr = 32'h200 + 32'(k * 4); if_instruction = 32'h3000 + 32'(k);
         #1;
         if (k > 0) begin
            checks++;
            if (id_instruction_addr !== 32'h200 + 32'((k - 1) * 4) || count !== 4'd1) begin
               failures++; $display("FAIL b2b_%0d got addr=%h count=%0d exp addr=%h count=1", k, id_instruction_addr, count, 32'h200 + (k - 1) * 4);
            end
         end
         step();
      end
      if_valid = 0;
      #1;
      checks++; if (id_instruction_addr !== 32'h24C) begin failures++; $display("FAIL b2b_last got=%h exp=0000024c", id_instruction_addr); end
      step();
      id_ready = 0;
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL b2b_empty got=%0d exp=0", count); end
   endtask

   task automatic test_flush();
      id_ready = 0;
      for (int i = 0; i < 5; i++) begin
         if_valid = 1; if_instruction_addr = 32'h300 + 32'(i * 4); if_instruction = 32'h4000 + 32'(i);
         step();
      end
      checks++; if (count !== 4'd5) begin failures++; $display("FAIL flush_pre_count got=%0d exp=5", count); end
      flush = 1; if_instruction_addr = 32'hDEAD0; if_instruction = 32'hDEAD; id_ready = 1;
      step();
      flush = 0; if_valid = 0; id_ready = 0;
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
      checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", id_valid); end
      checks++; if (id_instruction_addr !== 32'h0) begin failures++; $display("FAIL flush_addr got=%h exp=0", id_instruction_addr); end
      step();
      step();
      checks++; if (id_valid !== 1'b0 || id_instruction_addr === 32'hDEAD0) begin failures++; $display("FAIL flush_stays_empty got valid=%b addr=%h exp 0/0", id_valid, id_instruction_addr); end
   endtask

   task automatic test_async_reset();
      id_ready = 0;
      for (int i = 0; i < 3; i++) begin
         if_valid = 1; if_instruction_addr = 32'h500 + 32'(i * 4); if_instruction = 32'h5000 + 32'(i);
         step();
      end
      if_valid = 0;
      checks++; if (count !== 4'd3) begin failures++; $display("FAIL areset_pre_count got=%0d exp=3", count); end
      #2 rst = 1;
      #1;
      checks++; if (count !== 4'd0) begin failures++; $display("FAIL areset_count got=%0d exp=0", count); end
      checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL areset_valid got=%b exp=0", id_valid); end
      checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL areset_ready got=%b exp=1", if_ready); end
      step();
      rst = 0;
      if_valid = 1; if_instruction_addr = 32'h400; if_instruction = 32'h6000;
      step();
      if_valid = 0;
      checks++; if (count !== 4'd1 || id_instruction_addr !== 32'h400) begin failures++; $display("FAIL areset_resume got count=%0d addr=%h exp 1/00000400", count, id_instruction_addr); end
   endtask

   initial begin
      test_reset();
      test_single_push();
      test_fill_drain();
      test_full_push_pop();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
